// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: system-bus address width, port/data limits, FSM state enum,
// per-port request and response records, index-width helper.
package sram_arb_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS = 48;
  localparam int SRAM_ARB_MAX_PORTS   = 8;
  localparam int SRAM_ARB_MAX_DBYTES  = 8;
  localparam int SRAM_ARB_MAX_DBITS   = 8 * SRAM_ARB_MAX_DBYTES;

  typedef enum logic {
    ST_IDLE = 1'b0,   // no owner, arbitrate every cycle
    ST_LOCK = 1'b1    // owner_q holds the grant until its last beat
  } arb_state_e;

  // One requester beat, widened to the largest supported data size.
  typedef struct packed {
    logic                            valid;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic                            write;
    logic [SRAM_ARB_MAX_DBITS-1:0]   wdata;
    logic [SRAM_ARB_MAX_DBYTES-1:0]  wstrb;
    logic                            last;
  } sram_req_type;

  typedef struct packed {
    logic                          valid;
    logic [SRAM_ARB_MAX_DBITS-1:0] rdata;
    logic                          err;
  } sram_resp_type;

  // Width of a port index; a single port still gets one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// sram_arb_if: requester-side and RAM-side signals of the SRAM arbiter.
// Latency: n/a (wiring only).
// Backpressure: o_req_ready per port; responses cannot be stalled.
// Ports: i_req_* per-port request vectors, o_req_ready, o_resp_* response,
// o_ram_* / i_ram_rdata to the single-port byte-enabled RAM.
// Modports: slave = arbiter view, master = requesters + RAM view.
interface sram_arb_if
  import sram_arb_pkg::*;
#(
  parameter int nports      = 2,
  parameter int abits       = 17,
  parameter int log2_dbytes = 3
);
  localparam int dbytes = 1 << log2_dbytes;
  localparam int dbits  = 8 * dbytes;

  logic [nports-1:0]                      i_req_valid;
  logic [nports*CFG_SYSBUS_ADDR_BITS-1:0] i_req_addr;
  logic [nports-1:0]                      i_req_write;
  logic [nports*dbits-1:0]                i_req_wdata;
  logic [nports*dbytes-1:0]               i_req_wstrb;
  logic [nports-1:0]                      i_req_last;
  logic [nports-1:0]                      o_req_ready;
  logic [nports-1:0]                      o_resp_valid;
  logic [dbits-1:0]                       o_resp_rdata;
  logic [nports-1:0]                      o_resp_err;
  logic [abits-1:0]                       o_ram_addr;
  logic                                   o_ram_wena;
  logic [dbytes-1:0]                      o_ram_wstrb;
  logic [dbits-1:0]                       o_ram_wdata;
  logic [dbits-1:0]                       i_ram_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_req_wstrb,
           i_req_last, i_ram_rdata,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_ram_addr, o_ram_wena, o_ram_wstrb, o_ram_wdata
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_req_wstrb,
           i_req_last, i_ram_rdata,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_ram_addr, o_ram_wena, o_ram_wstrb, o_ram_wdata
  );

endinterface

// File: rtl/sram_arb_rrsel.sv
// sram_arb_rrsel: pick the first set request bit searching upward from start.
// Latency: combinational.
// Backpressure: none.
// Ports: req (request vector), start (search origin) -> grant (one-hot),
// idx (binary index of grant), any (some request set).
module sram_arb_rrsel
  import sram_arb_pkg::*;
#(
  parameter  int nports = 2,
  localparam int iw     = idx_bits(nports)
) (
  input  logic [nports-1:0] req,
  input  logic [iw-1:0]     start,
  output logic [nports-1:0] grant,
  output logic [iw-1:0]     idx,
  output logic              any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < nports; i++) begin
      // candidate port = (start + i) mod nports
      j = int'(start) + i;
      if (j >= nports) j = j - nports;
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = iw'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arb.sv
// sram_arb: shares one single-port byte-enabled SRAM among nports requesters.
// Latency: request accepted in cycle N -> response in cycle N+1; 1 beat/cycle.
// Backpressure: one o_req_ready per cycle, held to the owner for a whole burst.
// Ports: i_clk, i_rst (sync, active-high), bus (sram_arb_if.slave).
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration; without it
// the lowest-index valid port wins whenever the arbiter is idle.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int nports      = 2,
  parameter int abits       = 17,
  parameter int log2_dbytes = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sram_arb_if.slave   bus
);

  localparam int dbytes = 1 << log2_dbytes;
  localparam int dbits  = 8 * dbytes;
  localparam int aw     = CFG_SYSBUS_ADDR_BITS;
  localparam int iw     = idx_bits(nports);

  arb_state_e       state_q, state_d;
  logic [iw-1:0]    owner_q, owner_d;
  logic [nports-1:0] resp_vld_q, resp_err_q;
  logic             rd_q;

  sram_req_type     req_arr [nports];
  sram_req_type     sel;
  logic [iw-1:0]    start, win_idx, sel_idx;
  logic [nports-1:0] win_grant, ready;
  logic             win_any, accept, oor;

`ifdef SRAM_ARB_RR_EN
  logic [iw-1:0]    rr_q, rr_d, nxt_idx;
  assign start   = rr_q;
  assign nxt_idx = (sel_idx == iw'(nports - 1)) ? '0 : sel_idx + 1'b1;
`else
  assign start   = '0;
`endif

  // Unpack the flat per-port vectors into request records.
  always_comb begin
    for (int p = 0; p < nports; p++) begin
      req_arr[p].valid = bus.i_req_valid[p];
      req_arr[p].addr  = bus.i_req_addr[p*aw +: aw];
      req_arr[p].write = bus.i_req_write[p];
      req_arr[p].wdata = SRAM_ARB_MAX_DBITS'(bus.i_req_wdata[p*dbits +: dbits]);
      req_arr[p].wstrb = SRAM_ARB_MAX_DBYTES'(bus.i_req_wstrb[p*dbytes +: dbytes]);
      req_arr[p].last  = bus.i_req_last[p];
    end
  end

  sram_arb_rrsel #(.nports(nports)) u_rrsel (
    .req   (bus.i_req_valid),
    .start (start),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Grant selection and next-state logic.
  always_comb begin
    sel_idx = win_idx;
    ready   = '0;
    state_d = state_q;
    owner_d = owner_q;
`ifdef SRAM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    if (state_q == ST_LOCK) begin
      sel_idx        = owner_q;
      ready[owner_q] = 1'b1;
    end else if (win_any) begin
      ready = win_grant;
    end
    // Nothing is accepted while reset is held, even mid-burst.
    if (i_rst) ready = '0;

    sel    = req_arr[sel_idx];
    accept = sel.valid & ready[sel_idx];
    oor    = |sel.addr[aw-1:abits];

    if (accept) begin
      if (sel.last) begin
        state_d = ST_IDLE;
`ifdef SRAM_ARB_RR_EN
        rr_d    = nxt_idx;
`endif
      end else begin
        state_d = ST_LOCK;
        owner_d = sel_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      resp_vld_q <= '0;
      resp_err_q <= '0;
      rd_q       <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      // ready is one-hot whenever a beat is accepted
      resp_vld_q <= accept ? ready : '0;
      resp_err_q <= (accept && oor) ? ready : '0;
      rd_q       <= accept & ~sel.write & ~oor;
`ifdef SRAM_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_ram_addr   = sel.addr[abits-1:0];
  assign bus.o_ram_wena   = accept & sel.write & ~oor;
  assign bus.o_ram_wstrb  = sel.wstrb[dbytes-1:0];
  assign bus.o_ram_wdata  = sel.wdata[dbits-1:0];

  // RAM data lines up with the registered response; writes and
  // out-of-range reads return zero.
  assign bus.o_resp_valid = resp_vld_q;
  assign bus.o_resp_err   = resp_err_q;
  assign bus.o_resp_rdata = rd_q ? bus.i_ram_rdata : '0;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed bench for sram_arb with a 1-cycle-latency RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arb;
    import sram_arb_pkg::*;

    localparam int NP = 2;
    localparam int AB = 17;
    localparam int L2 = 3;
    localparam int AW = CFG_SYSBUS_ADDR_BITS;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sram_arb_if #(.nports(NP), .abits(AB), .log2_dbytes(L2)) bus ();

    sram_arb #(.nports(NP), .abits(AB), .log2_dbytes(L2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [int];
    initial bus.i_ram_rdata = '0;
    always @(posedge clk) begin
        int a;
        logic [63:0] w;
        a = int'(bus.o_ram_addr);
        if (bus.o_ram_wena) begin
            w = mem.exists(a) ? mem[a] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (bus.o_ram_wstrb[b]) w[8*b +: 8] = bus.o_ram_wdata[8*b +: 8];
            mem[a] = w;
        end
        bus.i_ram_rdata <= mem.exists(a) ? mem[a] : 64'h0;
    end

    task automatic chk(input string tag, input logic ok, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.i_req_valid = '0;
        bus.i_req_write = '0;
        bus.i_req_last  = '0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_req_wstrb = '0;
    endtask

    task automatic req(input int p, input logic wr, input logic [47:0] a,
                       input logic [63:0] d, input logic [7:0] s, input logic l);
        bus.i_req_valid[p]          = 1'b1;
        bus.i_req_write[p]          = wr;
        bus.i_req_addr[p*AW +: AW]  = a;
        bus.i_req_wdata[p*64 +: 64] = d;
        bus.i_req_wstrb[p*8 +: 8]   = s;
        bus.i_req_last[p]           = l;
    endtask

    logic [1:0] alt_exp [4];

    initial begin
`ifdef SRAM_ARB_RR_EN
        alt_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        alt_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b1;
        clr();
        req(0, 1'b0, 48'h10, 64'h0, 8'h00, 1'b1);
        tick();
        tick();
        #4;
        chk("rst_ready", bus.o_req_ready === 2'b00, bus.o_req_ready, 2'b00);
        chk("rst_resp_valid", bus.o_resp_valid === 2'b00, bus.o_resp_valid, 2'b00);
        chk("rst_resp_err", bus.o_resp_err === 2'b00, bus.o_resp_err, 2'b00);
        chk("rst_resp_rdata", bus.o_resp_rdata === 64'h0, bus.o_resp_rdata, 64'h0);
        chk("rst_wena", bus.o_ram_wena === 1'b0, bus.o_ram_wena, 1'b0);
        tick();
        rst = 1'b0;
        clr();

        req(0, 1'b1, 48'h10, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 1'b1);
        #4;
        chk("wr_ready", bus.o_req_ready === 2'b01, bus.o_req_ready, 2'b01);
        chk("wr_wena", bus.o_ram_wena === 1'b1, bus.o_ram_wena, 1'b1);
        chk("wr_addr", bus.o_ram_addr === 17'h10, bus.o_ram_addr, 17'h10);
        chk("wr_wdata", bus.o_ram_wdata === 64'hA5A5A5A5_5A5A5A5A, bus.o_ram_wdata,
            64'hA5A5A5A5_5A5A5A5A);
        tick();
        chk("wr_resp_valid", bus.o_resp_valid === 2'b01, bus.o_resp_valid, 2'b01);
        chk("wr_resp_err", bus.o_resp_err === 2'b00, bus.o_resp_err, 2'b00);
        chk("wr_resp_rdata", bus.o_resp_rdata === 64'h0, bus.o_resp_rdata, 64'h0);
        clr();
        req(0, 1'b0, 48'h10, 64'h0, 8'h00, 1'b1);
        #4;
        chk("rd_ready", bus.o_req_ready === 2'b01, bus.o_req_ready, 2'b01);
        chk("rd_wena", bus.o_ram_wena === 1'b0, bus.o_ram_wena, 1'b0);
        tick();
        chk("rd_resp_valid", bus.o_resp_valid === 2'b01, bus.o_resp_valid, 2'b01);
        chk("rd_resp_rdata", bus.o_resp_rdata === 64'hA5A5A5A5_5A5A5A5A, bus.o_resp_rdata,
            64'hA5A5A5A5_5A5A5A5A);
        chk("rd_resp_err", bus.o_resp_err === 2'b00, bus.o_resp_err, 2'b00);

        clr();
        req(0, 1'b0, 48'h10, 64'h0, 8'h00, 1'b1);
        req(1, 1'b0, 48'h10, 64'h0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("alt_ready", bus.o_req_ready === alt_exp[k], bus.o_req_ready, alt_exp[k]);
            tick();
            chk("alt_resp_valid", bus.o_resp_valid === alt_exp[k], bus.o_resp_valid,
                alt_exp[k]);
        end

        clr();
        req(1, 1'b1, 48'h20, 64'h1111, 8'hFF, 1'b0);
        #4;
        chk("bst1_ready", bus.o_req_ready === 2'b10, bus.o_req_ready, 2'b10);
        chk("bst1_wena", bus.o_ram_wena === 1'b1, bus.o_ram_wena, 1'b1);
        tick();
        req(0, 1'b0, 48'h21, 64'h0, 8'h00, 1'b1);
        req(1, 1'b1, 48'h21, 64'h2222, 8'hFF, 1'b0);
        #4;
        chk("bst2_ready", bus.o_req_ready === 2'b10, bus.o_req_ready, 2'b10);
        tick();
        chk("bst2_resp_valid", bus.o_resp_valid === 2'b10, bus.o_resp_valid, 2'b10);
        req(1, 1'b1, 48'h22, 64'h3333, 8'hFF, 1'b0);
        #4;
        chk("bst3_ready", bus.o_req_ready === 2'b10, bus.o_req_ready, 2'b10);
        tick();
        req(1, 1'b1, 48'h23, 64'h4444, 8'hFF, 1'b1);
        #4;
        chk("bst4_ready", bus.o_req_ready === 2'b10, bus.o_req_ready, 2'b10);
        chk("bst4_addr", bus.o_ram_addr === 17'h23, bus.o_ram_addr, 17'h23);
        tick();
        bus.i_req_valid[1] = 1'b0;
        #4;
        chk("bst5_ready", bus.o_req_ready === 2'b01, bus.o_req_ready, 2'b01);
        tick();
        chk("bst5_resp_valid", bus.o_resp_valid === 2'b01, bus.o_resp_valid, 2'b01);
        chk("bst5_rdata", bus.o_resp_rdata === 64'h2222, bus.o_resp_rdata, 64'h2222);

        clr();
        req(0, 1'b1, 48'h0, 64'h01234567_89ABCDEF, 8'hFF, 1'b1);
        tick();
        req(0, 1'b1, 48'h20000, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1);
        #4;
        chk("oor_ready", bus.o_req_ready === 2'b01, bus.o_req_ready, 2'b01);
        chk("oor_wena", bus.o_ram_wena === 1'b0, bus.o_ram_wena, 1'b0);
        tick();
        chk("oor_resp_valid", bus.o_resp_valid === 2'b01, bus.o_resp_valid, 2'b01);
        chk("oor_resp_err", bus.o_resp_err === 2'b01, bus.o_resp_err, 2'b01);
        req(0, 1'b0, 48'h0, 64'h0, 8'h00, 1'b1);
        tick();
        chk("oor_old_rdata", bus.o_resp_rdata === 64'h01234567_89ABCDEF, bus.o_resp_rdata,
            64'h01234567_89ABCDEF);
        chk("oor_old_err", bus.o_resp_err === 2'b00, bus.o_resp_err, 2'b00);

        req(0, 1'b1, 48'h30, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1);
        tick();
        req(0, 1'b1, 48'h30, 64'h11223344_55667788, 8'h0F, 1'b1);
        #4;
        chk("part_wstrb", bus.o_ram_wstrb === 8'h0F, bus.o_ram_wstrb, 8'h0F);
        tick();
        req(0, 1'b0, 48'h30, 64'h0, 8'h00, 1'b1);
        tick();
        chk("part_rdata", bus.o_resp_rdata === 64'hFFFFFFFF_55667788, bus.o_resp_rdata,
            64'hFFFFFFFF_55667788);

        clr();
        req(0, 1'b1, 48'h40, 64'hAAAA, 8'hFF, 1'b0);
        #4;
        chk("rstb1_ready", bus.o_req_ready === 2'b01, bus.o_req_ready, 2'b01);
        tick();
        chk("rstb1_resp_valid", bus.o_resp_valid === 2'b01, bus.o_resp_valid, 2'b01);
        rst = 1'b1;
        req(0, 1'b1, 48'h41, 64'hBBBB, 8'hFF, 1'b1);
        #4;
        chk("rstb2_ready", bus.o_req_ready === 2'b00, bus.o_req_ready, 2'b00);
        chk("rstb2_wena", bus.o_ram_wena === 1'b0, bus.o_ram_wena, 1'b0);
        tick();
        chk("rstb2_resp_valid", bus.o_resp_valid === 2'b00, bus.o_resp_valid, 2'b00);
        rst = 1'b0;
        clr();
        req(1, 1'b0, 48'h10, 64'h0, 8'h00, 1'b1);
        #4;
        chk("post_rst_ready", bus.o_req_ready === 2'b10, bus.o_req_ready, 2'b10);
        tick();
        chk("post_rst_resp_valid", bus.o_resp_valid === 2'b10, bus.o_resp_valid, 2'b10);
        chk("post_rst_rdata", bus.o_resp_rdata === 64'hA5A5A5A5_5A5A5A5A, bus.o_resp_rdata,
            64'hA5A5A5A5_5A5A5A5A);
        req(1, 1'b0, 48'h41, 64'h0, 8'h00, 1'b1);
        tick();
        chk("rst_beat_not_written", bus.o_resp_rdata === 64'h0, bus.o_resp_rdata, 64'h0);
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
